r_type_assembler: RTL and testbench
===================================

R_TYPE_ASSEMBLER -- requirements
Module: r_type_assembler

Interface
REQ-001 SHALL have parameter WORDSIZE, default 64, memory address width.
REQ-002 SHALL have parameter SIZE, default 32, instruction width.
REQ-003 SHALL have parameter DEPTH, default 4, FIFO entries (power of 2, >=2).
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  load base_addr, flush FIFO, enter RUN.
REQ-007 SHALL have port base_addr  input  WORDSIZE  first write address.
REQ-008 SHALL have port in_valid  input  1  field set present.
REQ-009 SHALL have port in_ready  output  1  field set can be accepted.
REQ-010 SHALL have ports funct7 (7), rs2 (5), rs1 (5), funct3 (3), rd (5), op_code (7), all inputs, carrying R-type fields.
REQ-011 SHALL have port mem_we  output  1  write request to instruction memory.
REQ-012 SHALL have port mem_addr  output  WORDSIZE  write address.
REQ-013 SHALL have port mem_wdata  output  SIZE  packed instruction.
REQ-014 SHALL have port mem_ready  input  1  memory accepts the write this cycle.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-016 SHALL have port err  output  1  sticky illegal-opcode flag.

Function
REQ-017 SHALL implement states IDLE and RUN; IDLE->RUN on start; RUN->RUN on start (re-initialize); no other transitions except reset.
REQ-018 SHALL drive in_ready = (state==RUN) && !full && !start.
REQ-019 SHALL accept a field set on an edge where in_valid && in_ready.
REQ-020 SHALL pack accepted fields as {funct7, rs2, rs1, funct3, rd, op_code} (bits 31:25, 24:20, 19:15, 14:12, 11:7, 6:0) and push them into the FIFO on the accepting edge.
REQ-021 SHALL drive mem_we = !empty, mem_wdata = FIFO head, mem_addr = address counter; no combinational path from in_* to mem_*.
REQ-022 SHALL give latency of one cycle: a word accepted at edge N into an empty FIFO appears with mem_we=1 in the cycle after edge N.
REQ-023 SHALL complete a write on an edge where mem_we && mem_ready: pop head, address counter += 4 (modulo 2^WORDSIZE, wraps silently).
REQ-024 SHALL hold mem_addr/mem_wdata stable while mem_we=1 and mem_ready=0.
REQ-025 SHALL, on simultaneous push and pop, leave count unchanged and preserve order; no push when full (no bypass); when full and popping, in_ready stays 0 that cycle.
REQ-026 SHALL, on start, set address counter to base_addr, empty the FIFO (pending words discarded), clear err; start has priority over a same-edge pop or push.
REQ-027 SHALL keep FIFO pointers wrapping modulo DEPTH; count ranges 0..DEPTH.

Reset
REQ-028 SHALL, on rst high at an edge, set state=IDLE, FIFO empty, count=0, address counter=0, err=0; rst overrides start.
REQ-029 SHALL have all outputs read 0 after reset: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, count=0, err=0.
REQ-030 SHALL, on reset mid-write, drop the pending write without completing it and discard all FIFO contents.

Configuration
REQ-031 SHALL, with RTYPE_OPCODE_CHECK_EN defined, still handshake an accepted field set whose op_code is neither 7'b0110011 nor 7'b0111011, but not push it, and set err (sticky until start/rst).
REQ-032 SHALL, without RTYPE_OPCODE_CHECK_EN, push every accepted field set regardless of op_code, with err tied to 0.

Verification
REQ-033 SHALL cover: rst, start with base_addr=0x1000, push funct7=0x20, rs2=2, rs1=1, funct3=0, rd=3, op_code=0x33 with mem_ready=1 -> mem_we=1 next cycle, mem_addr=0x1000, mem_wdata=0x402081B3.
REQ-034 SHALL cover: mem_ready=0, push 4 words -> count=4, in_ready=0; then mem_ready=1 -> 4 writes at 0x1000,0x1004,0x1008,0x100C in push order.
REQ-035 SHALL cover: base_addr=0xFFFF_FFFF_FFFF_FFFC, two writes -> addresses 0xFFFF_FFFF_FFFF_FFFC then 0x0.
REQ-036 SHALL cover: FIFO holding 2 words and start asserted with base_addr=0x2000 -> count=0, mem_we=0 next cycle, err=0, next write at 0x2000.
REQ-037 SHALL cover: with RTYPE_OPCODE_CHECK_EN, push op_code=0x13 -> count unchanged, err=1; without the macro the same word is written as 0x...13.
REQ-038 SHALL cover: rst asserted while mem_we=1 and mem_ready=0 -> all outputs 0 next cycle, in_ready=0 until start.

Source files
------------

// File: rtl/r_type_assembler.sv
// r_type_assembler: packs RISC-V R-type field sets into 32-bit words and streams them to instruction memory.
// Latency: a field set accepted at edge N appears on mem_* (mem_we=1) in the cycle after edge N.
// Backpressure: mem_ready=0 holds the head word; the DEPTH-entry FIFO fills and then in_ready drops.
// Optional build macro RTYPE_OPCODE_CHECK_EN: drop non-R-type opcodes and raise sticky err.

// Small synchronous FIFO with flush; head is visible combinationally from storage.
module r_type_assembler_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO or a pop from an empty one is ignored outright.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; flush wins over any same-cycle push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: stale entries are never visible because empty gates the head downstream.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i && !rst) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end
endmodule

module r_type_assembler #(
  parameter int WORDSIZE = 64,
  parameter int SIZE     = 32,
  parameter int DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WORDSIZE-1:0]    base_addr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [6:0]             funct7,
  input  logic [4:0]             rs2,
  input  logic [4:0]             rs1,
  input  logic [2:0]             funct3,
  input  logic [4:0]             rd,
  input  logic [6:0]             op_code,
  output logic                   mem_we,
  output logic [WORDSIZE-1:0]    mem_addr,
  output logic [SIZE-1:0]        mem_wdata,
  input  logic                   mem_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err
);
  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [WORDSIZE-1:0] ADDR_STEP = WORDSIZE'(4);

  state_t                 state_q, state_d;
  logic [WORDSIZE-1:0]    addr_q, addr_d;
  logic [SIZE-1:0]        packed_word;
  logic [SIZE-1:0]        fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   accept;
  logic                   opcode_ok;
  logic                   push;
  logic                   pop;

  // Start both launches and restarts a run, so the only non-reset transition target is RUN.
  always_comb begin
    state_d = state_q;
    if (start) state_d = S_RUN;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Start blocks acceptance on its own edge since that edge flushes the FIFO anyway.
  assign in_ready = (state_q == S_RUN) && !fifo_full && !start;
  assign accept   = in_valid && in_ready;

`ifdef RTYPE_OPCODE_CHECK_EN
  logic err_q, err_d;

  assign opcode_ok = (op_code == 7'b0110011) || (op_code == 7'b0111011);

  // Illegal opcodes still complete the handshake; they just leave a sticky mark until start or reset.
  always_comb begin
    err_d = err_q;
    if (start)                    err_d = 1'b0;
    else if (accept && !opcode_ok) err_d = 1'b1;
  end

  // Sticky error register.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign opcode_ok = 1'b1;
  assign err       = 1'b0;
`endif

  assign push        = accept && opcode_ok;
  assign packed_word = SIZE'({funct7, rs2, rs1, funct3, rd, op_code});

  // mem_* come only from registered state, so there is no in_* -> mem_* combinational path.
  assign mem_we    = !fifo_empty;
  assign pop       = mem_we && mem_ready;
  assign mem_addr  = addr_q;
  assign mem_wdata = fifo_empty ? '0 : fifo_head;

  r_type_assembler_fifo #(
    .W     (SIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (start),
    .push_i  (push),
    .din_i   (packed_word),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count)
  );

  // Write address: reload on start, otherwise advance by one word per completed write, wrapping silently.
  always_comb begin
    addr_d = addr_q;
    if (start)    addr_d = base_addr;
    else if (pop) addr_d = addr_q + ADDR_STEP;
  end

  // Address register.
  always_ff @(posedge clk) begin
    if (rst) addr_q <= '0;
    else     addr_q <= addr_d;
  end
endmodule

// File: tb/tb_r_type_assembler.sv
module tb_r_type_assembler;
  localparam int WORDSIZE = 64;
  localparam int SIZE     = 32;
  localparam int DEPTH    = 4;
  localparam int CW       = $clog2(DEPTH) + 1;

  logic                clk = 1'b0;
  logic                rst, start, in_valid, in_ready, mem_we, mem_ready, err;
  logic [WORDSIZE-1:0] base_addr, mem_addr;
  logic [SIZE-1:0]     mem_wdata;
  logic [6:0]          funct7, op_code;
  logic [4:0]          rs2, rs1, rd;
  logic [2:0]          funct3;
  logic [CW-1:0]       count;

  always #5 clk = ~clk;

  r_type_assembler #(.WORDSIZE(WORDSIZE), .SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready),
    .funct7(funct7), .rs2(rs2), .rs1(rs1), .funct3(funct3), .rd(rd), .op_code(op_code),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .count(count), .err(err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: a run flag, a queue of pending words, the next write address and the error flag.
  bit          m_run;
  logic [31:0] m_q[$];
  logic [63:0] m_addr;
  bit          m_err;

  function automatic bit op_ok(input logic [6:0] op);
`ifdef RTYPE_OPCODE_CHECK_EN
    return (op == 7'h33) || (op == 7'h3B);
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit exp_in_ready();
    return m_run && (m_q.size() < DEPTH) && !start;
  endfunction

  task automatic compare_all();
    check("in_ready",  64'(in_ready),  64'(exp_in_ready()));
    check("mem_we",    64'(mem_we),    64'(m_q.size() != 0));
    check("mem_addr",  64'(mem_addr),  m_addr);
    check("mem_wdata", 64'(mem_wdata), (m_q.size() != 0) ? 64'(m_q[0]) : 64'h0);
    check("count",     64'(count),     64'(m_q.size()));
    check("err",       64'(err),       64'(m_err));
  endtask

  // Advance the model by one edge using the inputs currently driven.
  task automatic model_edge();
    bit rdy;
    rdy = exp_in_ready();
    if (rst) begin
      m_run = 0; m_q.delete(); m_addr = '0; m_err = 0;
    end else if (start) begin
      m_run = 1; m_q.delete(); m_addr = 64'(base_addr); m_err = 0;
    end else begin
      if (m_q.size() != 0 && mem_ready) begin
        void'(m_q.pop_front());
        m_addr = m_addr + 64'd4;
      end
      if (in_valid && rdy) begin
        if (op_ok(op_code)) m_q.push_back({funct7, rs2, rs1, funct3, rd, op_code});
        else                m_err = 1;
      end
    end
  endtask

  // One clock: compare outputs mid-cycle, update the model, then return at the next falling edge.
  task automatic cycle();
    #1;
    compare_all();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_fields(input logic [6:0] f7, input logic [4:0] r2, input logic [4:0] r1,
                            input logic [2:0] f3, input logic [4:0] d, input logic [6:0] op);
    funct7 = f7; rs2 = r2; rs1 = r1; funct3 = f3; rd = d; op_code = op;
  endtask

  task automatic rand_fields(input logic [6:0] op);
    set_fields(7'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), op);
  endtask

  task automatic do_start(input logic [63:0] base);
    start = 1; base_addr = base;
    cycle();
    start = 0;
  endtask

  task automatic push_one(input logic [6:0] op, output logic [31:0] word);
    rand_fields(op);
    word = {funct7, rs2, rs1, funct3, rd, op_code};
    in_valid = 1;
    cycle();
    in_valid = 0;
  endtask

  logic [31:0] words[4];
  logic [31:0] w;
  logic [6:0]  rop;

  initial begin
    rst = 1; start = 0; base_addr = '0; in_valid = 0; mem_ready = 0;
    set_fields(0, 0, 0, 0, 0, 0);
    m_run = 0; m_addr = '0; m_err = 0;
    @(posedge clk);
    @(negedge clk);
    cycle();
    rst = 0;
    check("rst_in_ready", 64'(in_ready), 64'h0);
    check("rst_mem_we",   64'(mem_we),   64'h0);
    check("rst_addr",     64'(mem_addr), 64'h0);
    check("rst_wdata",    64'(mem_wdata), 64'h0);
    check("rst_count",    64'(count),    64'h0);
    check("rst_err",      64'(err),      64'h0);
    cycle();

    // Basic packing example.
    do_start(64'h1000);
    mem_ready = 1;
    set_fields(7'h20, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33);
    in_valid = 1;
    cycle();
    in_valid = 0;
    check("basic_we",    64'(mem_we),    64'h1);
    check("basic_addr",  64'(mem_addr),  64'h1000);
    check("basic_wdata", 64'(mem_wdata), 64'h402081B3);
    cycle();

    // Fill under backpressure, then drain in order.
    do_start(64'h1000);
    mem_ready = 0;
    for (int i = 0; i < 4; i++) push_one(7'h33, words[i]);
    check("full_count",    64'(count),    64'd4);
    check("full_in_ready", 64'(in_ready), 64'h0);
    mem_ready = 1;
    for (int i = 0; i < 4; i++) begin
      check("drain_addr",  64'(mem_addr),  64'h1000 + 64'(4 * i));
      check("drain_wdata", 64'(mem_wdata), 64'(words[i]));
      cycle();
    end
    check("drain_empty", 64'(mem_we), 64'h0);

    // Address wrap at the top of the address space.
    do_start(64'hFFFF_FFFF_FFFF_FFFC);
    mem_ready = 0;
    push_one(7'h3B, w);
    push_one(7'h33, w);
    mem_ready = 1;
    check("wrap_addr0", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFC);
    cycle();
    check("wrap_addr1", 64'(mem_addr), 64'h0);
    cycle();

    // Start flushes pending words and wins over a same-edge push and pop.
    do_start(64'h1000);
    mem_ready = 0;
    push_one(7'h33, w);
    push_one(7'h33, w);
    check("flush_pre_count", 64'(count), 64'd2);
    start = 1; base_addr = 64'h2000; in_valid = 1; mem_ready = 1;
    cycle();
    start = 0; in_valid = 0; mem_ready = 0;
    check("flush_count", 64'(count),  64'h0);
    check("flush_we",    64'(mem_we), 64'h0);
    check("flush_err",   64'(err),    64'h0);
    push_one(7'h33, w);
    check("flush_addr",  64'(mem_addr), 64'h2000);
    mem_ready = 1;
    cycle();

    // Non-R-type opcode.
    do_start(64'h3000);
    mem_ready = 0;
    push_one(7'h13, w);
`ifdef RTYPE_OPCODE_CHECK_EN
    check("op13_count", 64'(count), 64'h0);
    check("op13_err",   64'(err),   64'h1);
    do_start(64'h3000);
    check("op13_err_clr", 64'(err), 64'h0);
`else
    check("op13_count", 64'(count),          64'h1);
    check("op13_wdata", 64'(mem_wdata[6:0]), 64'h13);
    check("op13_err",   64'(err),            64'h0);
`endif

    // Reset during a stalled write.
    do_start(64'h4000);
    mem_ready = 0;
    push_one(7'h33, w);
    check("mid_we", 64'(mem_we), 64'h1);
    rst = 1;
    cycle();
    rst = 0;
    check("mid_in_ready", 64'(in_ready),  64'h0);
    check("mid_mem_we",   64'(mem_we),    64'h0);
    check("mid_addr",     64'(mem_addr),  64'h0);
    check("mid_wdata",    64'(mem_wdata), 64'h0);
    check("mid_count",    64'(count),     64'h0);
    check("mid_err",      64'(err),       64'h0);
    in_valid = 1; mem_ready = 1;
    for (int i = 0; i < 3; i++) begin
      rand_fields(7'h33);
      cycle();
    end
    in_valid = 0;

    // Random traffic against the model.
    do_start({$urandom, $urandom});
    for (int blk = 0; blk < 15; blk++) begin
      int rdy_pct, vld_pct;
      rdy_pct = $urandom_range(10, 100);
      vld_pct = $urandom_range(10, 100);
      for (int i = 0; i < 200; i++) begin
        rst       = ($urandom_range(0, 299) == 0);
        start     = ($urandom_range(0, 63) == 0);
        base_addr = {$urandom, $urandom};
        in_valid  = ($urandom_range(1, 100) <= vld_pct);
        mem_ready = ($urandom_range(1, 100) <= rdy_pct);
        case ($urandom_range(0, 3))
          0:       rop = 7'h3B;
          1:       rop = 7'($urandom);
          default: rop = 7'h33;
        endcase
        rand_fields(rop);
        cycle();
      end
    end
    rst = 0; start = 0; in_valid = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
